// File: rtl/pc_ras_unit_if.sv
// rtl/pc_ras_unit_if.sv - control/status bundle between the fetch-stage PC unit and its sequencer
//
// Purpose: groups the request inputs and status outputs of pc_ras_unit.
// Modports:
//   master - request side: drives stall/jump/branch/call/ret/clr_err/target_addr,
//            observes pc_out, ras_top, ras_count, ras_full, ras_empty,
//            ras_overflow, ras_underflow (and redirect/prev_pc when built in).
//   slave  - the PC unit itself (directions reversed).
// Optional feature macro: PC_RAS_REDIRECT_EN adds redirect and prev_pc.
interface pc_ras_unit_if #(
  parameter int ADDR_W    = 16,
  parameter int RAS_DEPTH = 8
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic              stall;
  logic              jump;
  logic              branch;
  logic              call;
  logic              ret;
  logic              clr_err;
  logic [ADDR_W-1:0] target_addr;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] ras_top;
  logic [CNT_W-1:0]  ras_count;
  logic              ras_full;
  logic              ras_empty;
  logic              ras_overflow;
  logic              ras_underflow;
`ifdef PC_RAS_REDIRECT_EN
  logic              redirect;
  logic [ADDR_W-1:0] prev_pc;

  modport master (
    output stall, jump, branch, call, ret, clr_err, target_addr,
    input  pc_out, ras_top, ras_count, ras_full, ras_empty,
           ras_overflow, ras_underflow, redirect, prev_pc
  );
  modport slave (
    input  stall, jump, branch, call, ret, clr_err, target_addr,
    output pc_out, ras_top, ras_count, ras_full, ras_empty,
           ras_overflow, ras_underflow, redirect, prev_pc
  );
`else
  modport master (
    output stall, jump, branch, call, ret, clr_err, target_addr,
    input  pc_out, ras_top, ras_count, ras_full, ras_empty,
           ras_overflow, ras_underflow
  );
  modport slave (
    input  stall, jump, branch, call, ret, clr_err, target_addr,
    output pc_out, ras_top, ras_count, ras_full, ras_empty,
           ras_overflow, ras_underflow
  );
`endif
endinterface

// File: rtl/pc_ras_unit.sv
// rtl/pc_ras_unit.sv - parametrised program counter with integrated return-address stack
//
// Purpose: fetch-stage PC. Each cycle applies the single highest-priority request
// (stall > jump > branch > call > ret > sequential). CALL pushes pc_out+INC onto
// an internal circular stack and RET pops it; overflow/underflow are sticky.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high reset
//   bus    - pc_ras_unit_if.slave: requests in (stall, jump, branch, call, ret,
//            clr_err, target_addr), status out (pc_out, ras_top, ras_count,
//            ras_full, ras_empty, ras_overflow, ras_underflow)
// Optional feature macro: PC_RAS_REDIRECT_EN adds redirect (one-cycle pulse after
// any redirecting request takes effect) and prev_pc (PC before last update).
module pc_ras_unit #(
  parameter int                ADDR_W    = 16,
  parameter int                RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] INC       = ADDR_W'(1)
) (
  input logic           clk,
  input logic           reset,
  pc_ras_unit_if.slave  bus
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  sp_q, sp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push;
  logic              redir;
  logic [ADDR_W-1:0] stack [RAS_DEPTH];

  logic [ADDR_W-1:0] pc_inc;
  logic [PTR_W-1:0]  top_idx;
  logic              full;
  logic              empty;
  logic [ADDR_W-1:0] top_val;

  assign pc_inc  = pc_q + INC;
  // sp_q points at the next free slot; PTR_W-bit subtraction wraps mod RAS_DEPTH.
  assign top_idx = sp_q - 1'b1;
  assign full    = (cnt_q == CNT_W'(RAS_DEPTH));
  assign empty   = (cnt_q == '0);
  assign top_val = empty ? '0 : stack[top_idx];

  always_comb begin
    pc_d  = pc_inc;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    redir = 1'b0;
    // Clear first so a setting event later in this block overrides it.
    if (bus.clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (bus.stall) begin
      pc_d = pc_q;
    end else if (bus.jump || bus.branch) begin
      pc_d  = bus.target_addr;
      redir = 1'b1;
    end else if (bus.call) begin
      pc_d  = bus.target_addr;
      push  = 1'b1;
      sp_d  = sp_q + 1'b1;
      redir = 1'b1;
      // When full the write lands on the oldest entry; count saturates.
      if (full) ovf_d = 1'b1;
      else      cnt_d = cnt_q + 1'b1;
    end else if (bus.ret) begin
      redir = 1'b1;
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        pc_d  = top_val;
        sp_d  = top_idx;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VEC;
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage has no reset; entries are only read below the count.
  always_ff @(posedge clk) begin
    if (push && !reset) stack[sp_q] <= pc_inc;
  end

  assign bus.pc_out        = pc_q;
  assign bus.ras_top       = top_val;
  assign bus.ras_count     = cnt_q;
  assign bus.ras_full      = full;
  assign bus.ras_empty     = empty;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;

`ifdef PC_RAS_REDIRECT_EN
  logic              redirect_q;
  logic [ADDR_W-1:0] prev_pc_q;

  // redir is only raised on non-stalled cycles, so a stall yields redirect = 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_q <= 1'b0;
      prev_pc_q  <= '0;
    end else begin
      redirect_q <= redir;
      if (!bus.stall) prev_pc_q <= pc_q;
    end
  end

  assign bus.redirect = redirect_q;
  assign bus.prev_pc  = prev_pc_q;
`else
  logic unused_redir;
  assign unused_redir = redir;
`endif
endmodule
